// File: rtl/mux2_sel_arbiter.sv
// Round-robin break-before-make arbiter driving a shared 2:1 mux select.
// Define MUX2_SEL_ARBITER_TIMEOUT_EN to force release after HOLD_MAX contended cycles.
module mux2_sel_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQA,
  input  logic REQB,
  input  logic LAST,
  output logic SEL,
  output logic GNTA,
  output logic GNTB,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    OWN_A,
    OWN_B
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   gnta_q, gnta_d;
  logic   gntb_q, gntb_d;
  logic   lastb_q, lastb_d;

  logic   own;
  logic   own_b;
  logic   mine;
  logic   other;
  logic   sel_req;
  logic   win;
  logic   tmo;

  assign own     = (state_q == OWN_A) || (state_q == OWN_B);
  assign own_b   = (state_q == OWN_B);
  assign mine    = own_b ? REQB : REQA;
  assign other   = own_b ? REQA : REQB;
  assign sel_req = sel_q ? REQB : REQA;
  assign win     = (REQA && REQB) ? ~lastb_q : REQB;

`ifdef MUX2_SEL_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo = own && other &&
               (cnt_q == CNT_W'(HOLD_MAX - 1));

  // Hold counter: cleared on OWN entry, saturating count of owned cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == GAP && sel_req)
      cnt_d = '0;
    else if (own && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // Hold counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [CNT_W-1:0] unused_hold;

  assign unused_hold = CNT_W'(HOLD_MAX);
  assign tmo         = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnta_d  = gnta_q;
    gntb_d  = gntb_q;
    lastb_d = lastb_q;
    unique case (state_q)
      IDLE: begin
        if (REQA || REQB) begin
          sel_d   = win;
          state_d = GAP;
        end
      end
      GAP: begin
        if (sel_req) begin
          state_d = sel_q ? OWN_B : OWN_A;
          gnta_d  = ~sel_q;
          gntb_d  = sel_q;
          lastb_d = sel_q;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A, OWN_B: begin
        if (!mine || LAST || tmo) begin
          gnta_d = 1'b0;
          gntb_d = 1'b0;
          if (other) begin
            sel_d   = ~own_b;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnta_d  = 1'b0;
        gntb_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      gnta_q  <= 1'b0;
      gntb_q  <= 1'b0;
      lastb_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnta_q  <= gnta_d;
      gntb_q  <= gntb_d;
      lastb_q <= lastb_d;
    end
  end

  assign SEL  = sel_q;
  assign GNTA = gnta_q;
  assign GNTB = gntb_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Bench for mux2_sel_arbiter: directed table, corner sequences, random vs model.
// Build with MUX2_SEL_ARBITER_TIMEOUT_EN to exercise forced release.
module tb_mux2_sel_arbiter;

  localparam int HM = 4;
  localparam int CW = 4;

  logic CLK, RST, REQA, REQB, LAST;
  logic SEL, GNTA, GNTB, BUSY;

  int checks = 0;
  int errors = 0;

  mux2_sel_arbiter #(.HOLD_MAX(HM), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .REQA(REQA), .REQB(REQB), .LAST(LAST),
    .SEL(SEL), .GNTA(GNTA), .GNTB(GNTB), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic a, b, l;
    logic sel, ga, gb, busy;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_i(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQA = 0; REQB = 0; LAST = 0;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
  endtask

  // Reference model: who is served, what phase, how long held.
  int  m_phase;
  logic m_sel, m_owner, m_lastb;
  int  m_held;

  function automatic logic pick(logic a, logic b);
    if (a && b) return ~m_lastb;
    return b;
  endfunction

  task automatic model_step(logic a, logic b, logic l);
    logic mine, oth, to;
    case (m_phase)
      0: if (a || b) begin m_sel = pick(a, b); m_phase = 1; end
      1: begin
        if (m_sel ? b : a) begin
          m_phase = 2; m_owner = m_sel; m_lastb = m_sel; m_held = 1;
        end else m_phase = 0;
      end
      default: begin
        mine = m_owner ? b : a;
        oth  = m_owner ? a : b;
`ifdef MUX2_SEL_ARBITER_TIMEOUT_EN
        to = oth && (m_held == HM);
`else
        to = 1'b0;
`endif
        if (!mine || l || to) begin
          if (oth) begin m_sel = ~m_owner; m_phase = 1; end
          else m_phase = 0;
        end else if (m_held < (1 << CW)) m_held++;
      end
    endcase
  endtask

  bit rr_a[10]   = '{0,1,1,1,0,0,0,0,0,1};
  bit rr_b[10]   = '{0,0,0,0,0,1,1,1,0,0};
  bit rr_sel[10] = '{0,0,0,0,1,1,1,1,0,0};

  initial begin
    int ng, run;
    logic psel;

    tbl[0]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1};
    tbl[1]  = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1};
    tbl[11] = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b1};
    tbl[12] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0};

    do_reset();
    chk("rst_sel", SEL, 1'b0);
    chk("rst_gnta", GNTA, 1'b0);
    chk("rst_gntb", GNTB, 1'b0);
    chk("rst_busy", BUSY, 1'b0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      REQA = tbl[i].a; REQB = tbl[i].b; LAST = tbl[i].l;
      edge1();
      chk($sformatf("tbl%0d_sel", i), SEL, tbl[i].sel);
      chk($sformatf("tbl%0d_gnta", i), GNTA, tbl[i].ga);
      chk($sformatf("tbl%0d_gntb", i), GNTB, tbl[i].gb);
      chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
    end

    // Async reset mid-OWN_B, then tie goes to A
    do_reset();
    REQB = 1;
    edge1(); edge1();
    chk("ownb_pre", GNTB, 1'b1);
    #2 RST = 1;
    #1;
    chk("async_sel", SEL, 1'b0);
    chk("async_gntb", GNTB, 1'b0);
    chk("async_gnta", GNTA, 1'b0);
    chk("async_busy", BUSY, 1'b0);
    edge1();
    RST = 0; REQA = 1; REQB = 1;
    edge1();
    chk("tie_sel", SEL, 1'b0);
    chk("tie_gap", GNTA | GNTB, 1'b0);
    edge1();
    chk("tie_gnta", GNTA, 1'b1);

    // Round robin with LAST on 3rd grant cycle
    do_reset();
    REQA = 1; REQB = 1;
    run = 0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk($sformatf("rr%0d_a", i), GNTA, rr_a[i]);
      chk($sformatf("rr%0d_b", i), GNTB, rr_b[i]);
      chk($sformatf("rr%0d_sel", i), SEL, rr_sel[i]);
      run  = (GNTA || GNTB) ? run + 1 : 0;
      LAST = (run == 3);
    end
    LAST = 0;

    // Contended hold: timeout vs unlimited
    do_reset();
    REQA = 1;
    edge1(); edge1();
    chk("to_own", GNTA, 1'b1);
    REQB = 1;
    ng = 1;
    for (int i = 0; i < 30; i++) begin
      edge1();
      if (!GNTA) break;
      ng++;
    end
`ifdef MUX2_SEL_ARBITER_TIMEOUT_EN
    chk_i("to_len", ng, HM);
    chk("to_gap_b", GNTB, 1'b0);
    chk("to_gap_sel", SEL, 1'b1);
    edge1();
    chk("to_gntb", GNTB, 1'b1);
`else
    chk_i("hold_len", ng, 31);
    chk("hold_gntb", GNTB, 1'b0);
`endif

    // Random stimulus against the model
    do_reset();
    m_phase = 0; m_sel = 0; m_owner = 0; m_lastb = 1; m_held = 0;
    psel = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) REQA = ~REQA;
      if ($urandom_range(3) == 0) REQB = ~REQB;
      LAST = ($urandom_range(5) == 0);
      @(posedge CLK);
      model_step(REQA, REQB, LAST);
      #1;
      chk("rnd_sel", SEL, m_sel);
      chk("rnd_gnta", GNTA, m_phase == 2 && !m_owner);
      chk("rnd_gntb", GNTB, m_phase == 2 && m_owner);
      chk("rnd_busy", BUSY, m_phase != 0);
      chk("rnd_onehot", GNTA && GNTB, 1'b0);
      if (SEL !== psel) chk("rnd_selglitch", GNTA || GNTB, 1'b0);
      psel = SEL;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_sel_arbiter.md
Name: mux2_sel_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 output mux between requester A (mux input IA) and requester B (mux input IB).
- Drives the mux SEL line (0 = A, 1 = B) and a one-hot grant.
- Break-before-make: a one-cycle gap with no grant always separates SEL changes from grant assertion, so the mux output never glitches between owners.
- Sits directly beside the mux cell in shared-path netlists.

Parameters:
- HOLD_MAX, 15: maximum owned cycles before forced release (used only with the optional feature); legal range 1..(2^CNT_W - 1).
- CNT_W, 4: width of the hold counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- REQA  input  1  request from A; level; must stay high while owning.
- REQB  input  1  request from B; same rules as REQA.
- LAST  input  1  current owner's final cycle; sampled only while a grant is high.
- SEL  output  1  registered mux select; 0 = IA, 1 = IB.
- GNTA  output  1  registered grant to A.
- GNTB  output  1  registered grant to B.
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous, active-high.
- Reset (asynchronous, takes effect immediately, including mid-ownership):
  - state = IDLE; SEL = 0; GNTA = GNTB = 0; BUSY = 0; hold counter = 0.
  - last_owner = B, so A wins the first tie.
- States: IDLE, GAP, OWN_A, OWN_B. All outputs are registered and change only on CLK edges.
- Winner rule:
  - Only one REQ high → that requester wins.
  - Both high → the requester that is not last_owner wins.
- IDLE:
  - Any REQ high at edge k → SEL := winner, go to GAP.
  - No REQ → stay in IDLE.
- GAP:
  - Grants are low.
  - Winner's REQ still high → go to OWN_winner, assert its GNT, last_owner := winner, counter := 0.
  - Winner's REQ dropped → go to IDLE; SEL holds its value.
- Latency: REQ sampled at edge k → SEL valid after edge k → GNT high after edge k+1. Fixed at 2 cycles; no bypass even when SEL already matches the winner.
- OWN_X release, at an edge where owner REQ = 0 or LAST = 1:
  - GNT drops at that edge.
  - Other REQ high → SEL := other, go to GAP (handoff).
  - Other REQ low → go to IDLE; SEL unchanged.
- Owner re-requests immediately while the other is pending: the other is served first (round robin).
- Non-owner REQ changes while in OWN have no effect until release.
- LAST while no grant is high: ignored.
- GNTA and GNTB are never both high. Neither grant is ever high in the same cycle that SEL changes.
- Hold counter:
  - Increments once per OWN cycle and saturates at 2^CNT_W - 1.
  - Wraps never.
  - Clears on entry to OWN.

Optional Feature:
- Macro: MUX2_SEL_ARBITER_TIMEOUT_EN.
- Defined: in OWN_X, if counter == HOLD_MAX - 1 and the other REQ is high, the grant is revoked at that edge even if owner REQ and LAST are high (same transition as a handoff). The owner thus holds at most HOLD_MAX grant cycles while contended. Uncontended ownership is unlimited.
- Undefined: no forced release; the counter logic is compiled out; HOLD_MAX and CNT_W are unused.

Test Plan:
- RST high mid-OWN_B (async, between edges) → SEL=0, GNTA=GNTB=0, BUSY=0 immediately; after release, REQA=REQB=1 → A granted first.
- REQA=1 alone at edge 0 → SEL=0 after edge 0; GNTA=1 after edge 1; BUSY=1 from edge 0; LAST=1 at edge 5 → GNTA=0, IDLE, BUSY=0 after edge 5.
- REQA=REQB=1 from reset, each asserts LAST on its 3rd grant cycle, both re-request continuously → grant sequence A, gap, B, gap, A. SEL toggles only in gap cycles, never with a grant high.
- REQB pulsed for exactly 1 cycle (captured at edge k, dropped before edge k+1) → SEL=1 after edge k, GAP aborts to IDLE after edge k+1, GNTB never asserted.
- With MUX2_SEL_ARBITER_TIMEOUT_EN, HOLD_MAX=4: A owns, REQB raised, A never asserts LAST → GNTA high exactly 4 cycles, then gap, then GNTB. Without the macro → GNTA held indefinitely.
- LAST=1 pulsed while IDLE and while in GAP → no state or output change.
